// File: rtl/apb4_pkg.sv
// Shared APB4 requester definitions: FSM encoding, PPROT bit positions and response codes.
package apb4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam int unsigned PPROT_PRIV   = 0;
    localparam int unsigned PPROT_NONSEC = 1;
    localparam int unsigned PPROT_INSTR  = 2;

    typedef enum logic [1:0] {
        RSP_OK      = 2'd0,
        RSP_SLVERR  = 2'd1,
        RSP_TIMEOUT = 2'd2
    } rsp_code_e;

    function automatic logic rsp_is_err(input rsp_code_e code);
        return code != RSP_OK;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter; expired_c flags the wait cycle that brings the count to TIMEOUT.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired_c
);
    localparam int unsigned CW     = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(LAST_I);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != SAT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = (TIMEOUT != 0) && en && (cnt_q >= LAST);

endmodule

// File: rtl/apb4_master_bridge.sv
// APB4 requester: one valid/ready command becomes one APB4 transfer, answered on a valid/ready response.
module apb4_master_bridge
    import apb4_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [2:0]              PPROT,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);
    localparam int unsigned SW = DATA_WIDTH / 8;

    apb_state_e            state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [SW-1:0]         pstrb_q, pstrb_d;
    logic [2:0]            pprot_q, pprot_d;

    logic                  timer_clr_c;
    logic                  timer_en_c;
    logic                  timer_expired_c;
    logic                  done_c;
    rsp_code_e             done_code_c;

    assign timer_en_c = (state_q == ST_ACCESS) && !PREADY;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (PCLK),
        .rst       (PRESET),
        .clr       (timer_clr_c),
        .en        (timer_en_c),
        .expired_c (timer_expired_c)
    );

    // Next-state and registered-output logic; APB address/control hold after the transfer.
    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        timer_clr_c   = 1'b0;
        done_c        = 1'b0;
        done_code_c   = RSP_OK;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = ST_SETUP;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    pwrite_d    = cmd_write;
                    paddr_d     = cmd_addr;
                    pwdata_d    = cmd_wdata;
                    pstrb_d     = cmd_write ? cmd_strb : '0;
                    pprot_d     = cmd_prot;
                    timer_clr_c = 1'b1;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                // A completing PREADY takes priority over an expiring timer.
                if (PREADY) begin
                    done_c      = 1'b1;
                    done_code_c = PSLVERR ? RSP_SLVERR : RSP_OK;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                end else if (timer_expired_c) begin
                    done_c      = 1'b1;
                    done_code_c = RSP_TIMEOUT;
                    rsp_rdata_d = '0;
                end
                if (done_c) begin
                    state_d       = ST_RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = rsp_is_err(done_code_c);
                    rsp_timeout_d = (done_code_c == RSP_TIMEOUT);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;
    assign PPROT       = pprot_q;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Self-checking bench for apb4_master_bridge: directed vector table, hand sequences and random traffic.
module tb_apb4_master_bridge;
    import apb4_pkg::*;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 16;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [2:0]    prot;
        int            waits;
        logic          slverr;
        logic [DW-1:0] prdata;
    } cmd_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          tout;
        int            lat;
    } exp_t;

    typedef struct {
        cmd_t c;
        exp_t e;
    } vec_t;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic [2:0]    cmd_prot;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic [SW-1:0] PSTRB;
    logic [2:0]    PPROT;

    int n_checks = 0;
    int n_fail   = 0;

    apb4_master_bridge #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .cmd_prot    (cmd_prot),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PSTRB       (PSTRB),
        .PPROT       (PPROT),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cmd_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic [SW-1:0] s, input logic [2:0] p, input int waits,
                                input logic se, input logic [DW-1:0] rd);
        cmd_t c;
        c.write = w; c.addr = a; c.wdata = d; c.strb = s; c.prot = p;
        c.waits = waits; c.slverr = se; c.prdata = rd;
        return c;
    endfunction

    function automatic exp_t mk_e(input logic [DW-1:0] rd, input logic err, input logic tout, input int lat);
        exp_t e;
        e.rdata = rd; e.err = err; e.tout = tout; e.lat = lat;
        return e;
    endfunction

    // Reference model: the completer answers after 'waits' wait states unless the timeout hits first.
    function automatic exp_t ref_model(input cmd_t c);
        exp_t e;
        bit   abort;
        abort   = (TO != 0) && (c.waits >= int'(TO));
        e.lat   = abort ? 2 + int'(TO) : 3 + c.waits;
        e.tout  = abort;
        e.err   = abort || c.slverr;
        e.rdata = (abort || c.write) ? '0 : c.prdata;
        return e;
    endfunction

    function automatic logic [53:0] bus_exp(input cmd_t c, input logic sel, input logic en);
        return {sel, en, c.write, c.addr, c.wdata, (c.write ? c.strb : 4'h0), c.prot};
    endfunction

    function automatic logic [53:0] bus_act();
        return {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT};
    endfunction

    task automatic drive_cmd(input cmd_t c);
        cmd_write = c.write;
        cmd_addr  = c.addr;
        cmd_wdata = c.wdata;
        cmd_strb  = c.strb;
        cmd_prot  = c.prot;
    endtask

    // Called at a negedge in IDLE; returns at the negedge inside SETUP.
    task automatic start_cmd(input cmd_t c);
        check("cmd_ready_idle", 128'(cmd_ready), 128'(1));
        drive_cmd(c);
        cmd_valid = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
    endtask

    // Plays the completer from SETUP onward, checks the response, then handshakes after 'hold' stall cycles.
    task automatic finish_xfer(input cmd_t c, input exp_t e, input int hold, input bit offer, input cmd_t nc);
        int cyc;
        int j;
        bit got;
        cyc = 1;
        got = 1'b0;
        PREADY = 1'b0;
        while (!got && cyc <= 40) begin
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                check("apb_bus", 128'(bus_act()), 128'(bus_exp(c, 1'b1, 1'(cyc > 1))));
                if (cyc >= 2) begin
                    j = cyc - 1;
                    if (j == c.waits + 1) begin
                        PREADY = 1'b1; PSLVERR = c.slverr; PRDATA = c.prdata;
                    end else begin
                        PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
                    end
                end
                @(posedge PCLK);
                @(negedge PCLK);
                cyc++;
            end
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        check("rsp_latency", 128'(got ? cyc : 99), 128'(e.lat));
        if (got) begin
            check("apb_idle_after_access", 128'(bus_act()), 128'(bus_exp(c, 1'b0, 1'b0)));
            check("rsp_fields", 128'({rsp_rdata, rsp_err, rsp_timeout}), 128'({e.rdata, e.err, e.tout}));
            for (int h = 0; h < hold; h++) begin
                if (offer) begin
                    drive_cmd(nc);
                    cmd_valid = 1'b1;
                end
                rsp_ready = 1'b0;
                @(posedge PCLK);
                @(negedge PCLK);
                check("rsp_hold", 128'({rsp_valid, cmd_ready, PSEL, rsp_rdata, rsp_err, rsp_timeout}),
                      128'({1'b1, 1'b0, 1'b0, e.rdata, e.err, e.tout}));
            end
            rsp_ready = 1'b1;
            @(posedge PCLK);
            @(negedge PCLK);
            rsp_ready = 1'b0;
            check("rsp_release", 128'({rsp_valid, PSEL}), 128'(0));
        end
    endtask

    initial begin
        vec_t tbl[7];
        cmd_t c;
        cmd_t b;
        exp_t e;
        int   waits;

        PRESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
        rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("reset_outputs",
              128'({cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE,
                    PADDR, PWDATA, PSTRB, PPROT}), 128'(0));
        PRESET = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);

        // Directed vectors: write, waited read, slave error, timeout edges, read with error.
        tbl[0].c = mk(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 3'b010, 0, 1'b0, 32'h0);
        tbl[0].e = mk_e(32'h0, 1'b0, 1'b0, 3);
        tbl[1].c = mk(1'b0, 12'h020, 32'h11111111, 4'hF, 3'b000, 3, 1'b0, 32'h12345678);
        tbl[1].e = mk_e(32'h12345678, 1'b0, 1'b0, 6);
        tbl[2].c = mk(1'b1, 12'h030, 32'hA5A5A5A5, 4'h3, 3'b001, 2, 1'b1, 32'h0);
        tbl[2].e = mk_e(32'h0, 1'b1, 1'b0, 5);
        tbl[3].c = mk(1'b0, 12'h040, 32'h0, 4'h0, 3'b100, 16, 1'b0, 32'h77777777);
        tbl[3].e = mk_e(32'h0, 1'b1, 1'b1, 18);
        tbl[4].c = mk(1'b0, 12'h050, 32'h0, 4'h0, 3'b011, 15, 1'b0, 32'hCAFEF00D);
        tbl[4].e = mk_e(32'hCAFEF00D, 1'b0, 1'b0, 18);
        tbl[5].c = mk(1'b0, 12'hFFF, 32'h0, 4'hF, 3'b111, 0, 1'b1, 32'h0BADBEEF);
        tbl[5].e = mk_e(32'h0BADBEEF, 1'b1, 1'b0, 3);
        tbl[6].c = mk(1'b1, 12'h060, 32'h01020304, 4'h5, 3'b000, 20, 1'b0, 32'h0);
        tbl[6].e = mk_e(32'h0, 1'b1, 1'b1, 18);

        for (int i = 0; i < 7; i++) begin
            start_cmd(tbl[i].c);
            finish_xfer(tbl[i].c, tbl[i].e, 0, 1'b0, tbl[i].c);
        end

        // Response back-pressure with the next command already offered.
        c = mk(1'b1, 12'h100, 32'hFEEDFACE, 4'hC, 3'b010, 1, 1'b0, 32'h0);
        b = mk(1'b0, 12'h104, 32'h0, 4'h0, 3'b001, 0, 1'b0, 32'h55AA55AA);
        start_cmd(c);
        finish_xfer(c, mk_e(32'h0, 1'b0, 1'b0, 4), 5, 1'b1, b);
        check("cmd_ready_after_handshake", 128'({cmd_ready, PSEL}), 128'({1'b1, 1'b0}));
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        finish_xfer(b, mk_e(32'h55AA55AA, 1'b0, 1'b0, 3), 0, 1'b0, b);

        // Reset in the middle of ACCESS discards the transfer.
        c = mk(1'b0, 12'h080, 32'h0, 4'h0, 3'b000, 30, 1'b0, 32'h0);
        start_cmd(c);
        PREADY = 1'b0;
        repeat (2) begin
            @(posedge PCLK);
            @(negedge PCLK);
        end
        check("access_before_reset", 128'(bus_act()), 128'(bus_exp(c, 1'b1, 1'b1)));
        PRESET = 1'b1;
        #1;
        check("reset_mid_access", 128'({PSEL, PENABLE, rsp_valid, cmd_ready}), 128'(0));
        @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        check("no_rsp_after_reset", 128'({rsp_valid, PSEL}), 128'(0));
        c = mk(1'b0, 12'h0A0, 32'h0, 4'h0, 3'b001, 1, 1'b0, 32'h9ABCDEF0);
        start_cmd(c);
        finish_xfer(c, mk_e(32'h9ABCDEF0, 1'b0, 1'b0, 4), 0, 1'b0, c);

        // Random traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            waits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 20)) : int'($urandom_range(0, 4));
            c = mk(1'($urandom), 12'($urandom), $urandom, 4'($urandom), 3'($urandom),
                   waits, 1'($urandom), $urandom);
            e = ref_model(c);
            start_cmd(c);
            finish_xfer(c, e, int'($urandom_range(0, 2)), 1'b0, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
